// File: rtl/serial_wide_add_ctrl.sv
// serial_wide_add_ctrl: adds two WIDTH-bit operands one nibble per clock through a single 4-bit ripple adder.
// Optional SERIAL_ADD_EARLY_EXIT_EN: finish as soon as the remaining nibbles and the carry are all zero.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;
    always_comb begin
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module serial_wide_add_ctrl #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [3:0]       nib_s;
    logic             nib_c;

    adder u_adder (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                sum_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
`ifdef SERIAL_ADD_EARLY_EXIT_EN
                // Unprocessed nibbles were cleared at accept, so stopping here leaves the sum correct.
                if (a_q == '0 && b_q == '0 && !carry_q) begin
                    cout_d  = 1'b0;
                    state_d = DONE;
                end else begin
`else
                begin
`endif
                    sum_d[4*cnt_q +: 4] = nib_s;
                    carry_d = nib_c;
                    a_d     = a_q >> 4;
                    b_d     = b_q >> 4;
                    if (cnt_q == CW'(N - 1)) begin
                        cout_d  = nib_c;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_wide_add_ctrl.sv
// tb_serial_wide_add_ctrl: directed and random checks of a 16-bit and a 1024-bit instance against an arithmetic model.
module tb_serial_wide_add_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic        iv16 = 0, ir16, cin16 = 0, ov16, or16 = 0, co16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    logic          iv1k = 0, ir1k, cin1k = 0, ov1k, or1k = 0, co1k;
    logic [1023:0] a1k = 0, b1k = 0, s1k;

    serial_wide_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16));
    serial_wide_add_ctrl #(.WIDTH(1024)) dut1k (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1k), .in_ready(ir1k), .a(a1k), .b(b1k), .cin(cin1k),
        .out_valid(ov1k), .out_ready(or1k), .sum(s1k), .cout(co1k));

    int n_chk = 0, n_fail = 0;
    logic [1024:0] m16 = 0, m1k = 0;

    task automatic check(input string name, input logic [1024:0] got, input logic [1024:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Whenever a result is presented it must equal the model's a+b+cin and no new operands may be accepted.
    always @(negedge clk) begin
        if (rst_n && ov16) begin
            check("sum16_vs_model", {1008'b0, co16, s16}, m16);
            check("in_ready16_in_done", 1025'(ir16), 1025'(0));
        end
        if (rst_n && ov1k) begin
            check("sum1k_vs_model", {co1k, s1k}, m1k);
            check("in_ready1k_in_done", 1025'(ir1k), 1025'(0));
        end
    end

    function automatic int model_lat(input int n, input logic [1024:0] a, input logic [1024:0] b, input logic cin);
`ifdef SERIAL_ADD_EARLY_EXIT_EN
        logic [1024:0] mask, low;
        for (int k = 0; k < n; k++) begin
            mask = (1025'(1) << (4 * k)) - 1'b1;
            low  = (a & mask) + (b & mask) + 1025'(cin);
            if ((a >> (4 * k)) == 0 && (b >> (4 * k)) == 0 && (low >> (4 * k)) == 0) return k + 1;
        end
`endif
        return n;
    endfunction

    function automatic logic outv(input bit big);
        return big ? ov1k : ov16;
    endfunction

    task automatic drive(input bit big, input logic v, input logic [1023:0] a, input logic [1023:0] b, input logic c);
        if (big) begin iv1k = v; a1k = a; b1k = b; cin1k = c; end
        else begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = c; end
    endtask

    // One transaction: accept, measure latency, hold the result for `hold` cycles, then hand it off.
    task automatic op(input bit big, input logic [1023:0] a, input logic [1023:0] b, input logic cin,
                      input int hold, input bit use_lit, input logic [16:0] lit, input int lit_lat);
        logic [1024:0] exp, ua, ub, held;
        int n, lat;
        n  = big ? 256 : 4;
        ua = big ? {1'b0, a} : {1009'b0, a[15:0]};
        ub = big ? {1'b0, b} : {1009'b0, b[15:0]};
        exp = ua + ub + 1025'(cin);
        @(negedge clk);
        check("in_ready_idle", 1025'(big ? ir1k : ir16), 1025'(1));
        drive(big, 1'b1, a, b, cin);
        @(posedge clk);
        if (big) m1k = exp; else m16 = exp;
        #1;
        drive(big, 1'b0, '1, '1, 1'b1);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!outv(big) && lat < n + 4);
        check("latency_model", 1025'(lat), 1025'(model_lat(n, ua, ub, cin)));
        if (lit_lat > 0) check("latency_literal", 1025'(lat), 1025'(lit_lat));
        if (use_lit) check("sum_literal", {1008'b0, co16, s16}, {1008'b0, lit});
        held = big ? {co1k, s1k} : {1008'b0, co16, s16};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive(big, i[0], 1024'h5a5a, 1024'h1111, 1'b1);
            check("out_valid_held", 1025'(outv(big)), 1025'(1));
        end
        @(negedge clk);
        drive(big, 1'b0, '0, '0, 1'b0);
        if (big) or1k = 1; else or16 = 1;
        @(posedge clk); #1;
        if (big) or1k = 0; else or16 = 0;
        if (hold > 0 || use_lit) begin
            check("out_valid_after_take", 1025'(outv(big)), 1025'(0));
            check("in_ready_after_take", 1025'(big ? ir1k : ir16), 1025'(1));
            check("sum_kept_after_take", big ? {co1k, s1k} : {1008'b0, co16, s16}, held);
        end
    endtask

    initial begin
        logic [1023:0] ra, rb;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("reset_in_ready", 1025'(ir16), 1025'(1));
        check("reset_out_valid", 1025'(ov16), 1025'(0));
        check("reset_sum_cout", {1008'b0, co16, s16}, 1025'(0));

        op(0, 1024'hFFFF, 1024'h0001, 0, 0, 1, 17'h1_0000, 4);
        op(0, 1024'h1234, 1024'h4321, 1, 10, 1, 17'h0_5556, 4);

        // Abort a run after two nibble edges.
        @(negedge clk);
        drive(0, 1'b1, 1024'hAAAA, 1024'h5555, 1'b0);
        @(posedge clk); m16 = 0; #1;
        drive(0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_outputs", {1007'b0, ov16, co16, s16}, 1025'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        op(0, 1024'h00FF, 1024'h0001, 0, 0, 1, 17'h0_0100, 4);

`ifdef SERIAL_ADD_EARLY_EXIT_EN
        op(0, 1024'h0003, 1024'h0001, 0, 0, 1, 17'h0_0004, 2);
        op(0, 1024'h0000, 1024'h0000, 0, 0, 1, 17'h0_0000, 1);
`else
        op(0, 1024'h0003, 1024'h0001, 0, 0, 1, 17'h0_0004, 4);
        op(0, 1024'h0000, 1024'h0000, 0, 0, 1, 17'h0_0000, 4);
`endif
        op(0, 1024'h8000, 1024'h8000, 1, 0, 1, 17'h1_0001, 4);

        op(1, '1, '1, 1, 2, 0, 17'h0, 0);
        op(1, '1, '0, 1, 0, 0, 17'h0, 0);
        for (int t = 0; t < 198; t++) begin
            for (int w = 0; w < 32; w++) begin
                ra[32*w +: 32] = $urandom;
                rb[32*w +: 32] = $urandom;
            end
            op(1, ra, rb, 1'($urandom), 0, 0, 17'h0, 0);
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
